// File: rtl/jalret_pkg.sv
// Shared constants for the JAL/JR return-address stack.
package jalret_pkg;
    localparam int DEPTH_DEFAULT = 8;
    localparam int W_DEFAULT     = 32;
    localparam int PTR_W_DEFAULT = $clog2(DEPTH_DEFAULT);
    // Same value the JAL link register resets to.
    localparam logic [31:0] RET_PC_RESET = 32'h0;
endpackage

// File: rtl/jalret_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
module jalret_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/jalret_stack.sv
// Circular return-address stack fed by JAL commits and drained by JR $ra.
// Build option RAS_OVERWRITE_EN: a push while full overwrites the oldest entry instead of being dropped.
module jalret_stack
    import jalret_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int W     = W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_pc,
    input  logic                     pop,
    output logic                     pop_valid,
    output logic [W-1:0]             pop_pc,
    output logic [W-1:0]             top_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf,
    output logic                     udf
);
    localparam int PTR_W = $clog2(DEPTH);
`ifdef RAS_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_addr;
    logic [W-1:0]     rd_data;
    logic             wr_en;
    logic             tail;

    assign top_idx = sp - PTR_W'(1);
    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign top_pc  = empty ? W'(RET_PC_RESET) : rd_data;
    // Tail call: hand back the old link and replace it in place.
    assign tail    = push && pop && !empty;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sp;
        if (tail) begin
            wr_en   = 1'b1;
            wr_addr = top_idx;
        end else if (push && (!full || OVERWRITE)) begin
            wr_en = 1'b1;
        end
    end

    jalret_mem #(.DEPTH(DEPTH), .W(W), .AW(PTR_W)) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (push_pc),
        .rd_addr (top_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sp        <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            pop_pc    <= W'(RET_PC_RESET);
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            pop_valid <= pop && !empty;
            udf       <= pop && empty;
            if (pop && !empty) pop_pc <= rd_data;
            if (push && full && !pop) ovf <= 1'b1;

            if (tail) begin
                sp    <= sp;
                count <= count;
            end else if (push) begin
                if (!full) begin
                    sp    <= sp + PTR_W'(1);
                    count <= count + (PTR_W+1)'(1);
                end else if (OVERWRITE) begin
                    sp <= sp + PTR_W'(1);
                end
            end else if (pop && !empty) begin
                sp    <= sp - PTR_W'(1);
                count <= count - (PTR_W+1)'(1);
            end
        end
    end
endmodule

// File: doc/jalret_stack.md
# jalret_stack

Return-address stack that consumes the link values produced on JAL and supplies them back on JR $ra. It sits beside the JAL link register in the multicycle datapath. JAL commits push the captured PC+4, and JR-through-$ra pops the most recent link as a predicted or confirmed return target. It is a circular LIFO with occupancy tracking and error flags, so the control FSM can fall back to the register-file $ra whenever the stack cannot supply a value.

## Interface
- DEPTH, 8, number of entries; power of two, 2..64
- W, 32, address width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- push  in  1  JAL commit strobe, one cycle per JAL
- push_pc  in  W  link value to store (ALU output holding PC+4)
- pop  in  1  JR $ra request strobe
- pop_valid  out  1  registered; pop_pc is meaningful this cycle
- pop_pc  out  W  registered return address
- top_pc  out  W  combinational view of the current top entry; 0 when empty
- count  out  $clog2(DEPTH)+1  current occupancy
- empty  out  1  count==0
- full  out  1  count==DEPTH
- ovf  out  1  sticky; set when a push happens while full
- udf  out  1  one-cycle pulse; pop while empty

## Operation
- Storage is DEPTH×W registers. sp points to the next free slot, modulo DEPTH. Top entry is mem[sp-1].
- Push only (not full): mem[sp]<=push_pc; sp<=sp+1; count+1.
- Push when full: behaviour is set by the macro (see Configuration). ovf<=1 in either case.
- Pop only (not empty): pop_pc<=mem[sp-1]; pop_valid<=1; sp<=sp-1; count-1.
- Pop when empty: pop_valid<=0, pop_pc holds its previous value, udf<=1 for one cycle, and state is unchanged.
- Push and pop in the same cycle:
  - Not empty: pop_pc<=mem[sp-1]; pop_valid<=1; mem[sp-1]<=push_pc; sp and count are unchanged. This is a tail call: return the old link, replace it.
  - Empty: push proceeds normally, count becomes 1, pop_valid=0, and udf pulses.
- pop_valid deasserts in every cycle without a pop.
- ovf clears only on reset.
- Pointer arithmetic wraps modulo DEPTH. count saturates at 0 and DEPTH and never wraps.

## Timing
- Reset values: sp=0, count=0, empty=1, full=0, pop_valid=0, pop_pc=0, ovf=0, udf=0, mem contents=0.
- Pop latency is 1 cycle: pop in cycle N gives pop_valid/pop_pc in cycle N+1.
- Push visibility is 1 cycle: push in cycle N updates top_pc, count, full and empty in cycle N+1.
- top_pc is combinational from registered state and has no path from push or pop.
- Reset asserted in the same cycle as push or pop wins, and the operation is discarded.
- Back-to-back pops on consecutive cycles are supported, one entry per cycle.

## Configuration
- RAS_OVERWRITE_EN defined: push when full overwrites the oldest entry. mem[sp]<=push_pc, sp<=sp+1, count stays DEPTH. The stack keeps the most recent DEPTH links.
- RAS_OVERWRITE_EN undefined: push when full is dropped and mem, sp and count are unchanged. The stack keeps the oldest DEPTH links.
- ovf sets in both builds.

## Structure
- Shared package jalret_pkg holds:
  - DEPTH_DEFAULT=8 and W_DEFAULT=32
  - the pointer-width localparam derived with $clog2
  - the reset constant RET_PC_RESET=32'h0, matching the link-register reset value
- One sub-module, jalret_mem: DEPTH×W register array with one synchronous write port, one asynchronous read port at sp-1, and synchronous reset-to-zero. It is instantiated once.
- Pointer, count and flag logic live in the top module.

## Test plan
- Reset, then pop with no push → pop_valid=0, udf pulses for 1 cycle, count=0, empty=1.
- Push 0x04, 0x10, 0x2C, then pop ×3 on consecutive cycles → pop_pc sequence 0x2C, 0x10, 0x04, each with pop_valid=1; then empty=1.
- DEPTH=8: push 0x100..0x124 (10 values, step 4) → full=1, ovf=1.
  - With RAS_OVERWRITE_EN, 8 pops return 0x124 down to 0x108.
  - Without it, 8 pops return 0x11C down to 0x100.
- Push 0x40, then push 0x80 together with pop in the same cycle → pop_pc=0x40, count stays 1, and top_pc=0x80 next cycle.
- Push 0x40 and 0x44, then assert reset together with pop → next cycle pop_valid=0, count=0, top_pc=0, ovf=0.
- Push on an empty stack together with pop → udf pulses, pop_valid=0, count=1, top_pc=push_pc.
